// File: rtl/xosera_pkg.sv
// -----------------------------------------------------------------------------
// xosera_pkg
// Shared types and constants for the VRAM arbiter.
//   vram_addr_t   : 16-bit VRAM word address (64K words)
//   vram_word_t   : 16-bit VRAM data word
//   vram_rd_tag_t : owner of the read data returning next cycle
//   BLIT_STARVE_DEFAULT : default blitter starvation limit (cycles)
// -----------------------------------------------------------------------------
package xosera_pkg;

    typedef logic [15:0] vram_addr_t;
    typedef logic [15:0] vram_word_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        VGEN = 2'd1,
        REGS = 2'd2,
        BLIT = 2'd3
    } vram_rd_tag_t;

    localparam int unsigned BLIT_STARVE_DEFAULT = 8;

endpackage

// File: rtl/vram_arb.sv
// -----------------------------------------------------------------------------
// vram_arb
// Single-port VRAM arbiter shared by the video generator, the host register
// interface and the optional blitter. Grant and VRAM port mux are combinational
// from the requests and registered state; read data returns one cycle after
// the grant with a per-requester valid strobe.
//
// Optional feature macro: VRAM_ARB_BLIT_EN
//   defined   : blitter port active, fixed priority with starvation counter
//   undefined : blitter inputs ignored, blit_ack/blit_rd_valid tied low
//
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   vgen_sel/vgen_addr         : video read request (always granted)
//   vgen_rd_valid              : rd_data holds video data
//   regs_req/wr/addr/data      : register-interface request
//   regs_ack, regs_rd_valid    : accept strobe, read-data strobe
//   blit_req/wr/addr/data      : blitter request (same semantics as regs)
//   blit_ack, blit_rd_valid    : accept strobe, read-data strobe
//   rd_data                    : pass-through of vram_data_out
//   vram_sel/wr_en/addr/data_in: VRAM port
//   vram_data_out              : VRAM read data (one cycle after access)
// -----------------------------------------------------------------------------
module vram_arb
    import xosera_pkg::*;
#(
    parameter int unsigned BLIT_STARVE = BLIT_STARVE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        vgen_sel,
    input  vram_addr_t  vgen_addr,
    output logic        vgen_rd_valid,

    input  logic        regs_req,
    input  logic        regs_wr,
    input  vram_addr_t  regs_addr,
    input  vram_word_t  regs_data,
    output logic        regs_ack,
    output logic        regs_rd_valid,

    input  logic        blit_req,
    input  logic        blit_wr,
    input  vram_addr_t  blit_addr,
    input  vram_word_t  blit_data,
    output logic        blit_ack,
    output logic        blit_rd_valid,

    output vram_word_t  rd_data,

    output logic        vram_sel,
    output logic        vram_wr_en,
    output vram_addr_t  vram_addr,
    output vram_word_t  vram_data_in,
    input  vram_word_t  vram_data_out
);

    // Grant source for this cycle; reuses the tag encoding (NONE = idle)
    vram_rd_tag_t grant_s;
    vram_rd_tag_t rd_tag_d;
    vram_rd_tag_t rd_tag_q;

`ifdef VRAM_ARB_BLIT_EN
    localparam logic [3:0] STARVE_MAX = 4'(BLIT_STARVE);

    logic [3:0] starve_cnt_d;
    logic [3:0] starve_cnt_q;
    logic       blit_starved_s;

    assign blit_starved_s = (starve_cnt_q == STARVE_MAX);
`else
    // Blitter inputs are intentionally ignored in this build
    logic unused_blit_s;
    assign unused_blit_s = ^{blit_req, blit_wr, blit_addr, blit_data, 4'(BLIT_STARVE)};
`endif

    // Fixed-priority grant decision; reset blocks every grant
    always_comb begin
        grant_s = NONE;
        if (reset) begin
            grant_s = NONE;
        end else if (vgen_sel) begin
            grant_s = VGEN;
`ifdef VRAM_ARB_BLIT_EN
        end else if (blit_req && blit_starved_s) begin
            grant_s = BLIT;
        end else if (regs_req) begin
            grant_s = REGS;
        end else if (blit_req) begin
            grant_s = BLIT;
`else
        end else if (regs_req) begin
            grant_s = REGS;
`endif
        end else begin
            grant_s = NONE;
        end
    end

    // VRAM port mux, acks and next read tag; idle address/data follow regs to limit toggling
    always_comb begin
        vram_sel     = 1'b0;
        vram_wr_en   = 1'b0;
        vram_addr    = regs_addr;
        vram_data_in = regs_data;
        regs_ack     = 1'b0;
        blit_ack     = 1'b0;
        rd_tag_d     = NONE;
        case (grant_s)
            VGEN: begin
                vram_sel  = 1'b1;
                vram_addr = vgen_addr;
                rd_tag_d  = VGEN;
            end
            REGS: begin
                vram_sel     = 1'b1;
                vram_wr_en   = regs_wr;
                vram_addr    = regs_addr;
                vram_data_in = regs_data;
                regs_ack     = 1'b1;
                if (regs_wr) begin
                    rd_tag_d = NONE;
                end else begin
                    rd_tag_d = REGS;
                end
            end
`ifdef VRAM_ARB_BLIT_EN
            BLIT: begin
                vram_sel     = 1'b1;
                vram_wr_en   = blit_wr;
                vram_addr    = blit_addr;
                vram_data_in = blit_data;
                blit_ack     = 1'b1;
                if (blit_wr) begin
                    rd_tag_d = NONE;
                end else begin
                    rd_tag_d = BLIT;
                end
            end
`endif
            default: begin
                rd_tag_d = NONE;
            end
        endcase
    end

    // Read tag register: remembers who owns the data arriving next cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_tag_q <= NONE;
        end else begin
            rd_tag_q <= rd_tag_d;
        end
    end

`ifdef VRAM_ARB_BLIT_EN
    // Starvation counter next value: count denied cycles, saturate at the limit
    always_comb begin
        starve_cnt_d = 4'd0;
        if (blit_req && !blit_ack) begin
            if (blit_starved_s) begin
                starve_cnt_d = starve_cnt_q;
            end else begin
                starve_cnt_d = starve_cnt_q + 4'd1;
            end
        end else begin
            starve_cnt_d = 4'd0;
        end
    end

    // Starvation counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`endif

    // Read-valid strobes decoded from the tag; reset suppresses a pending strobe
    always_comb begin
        vgen_rd_valid = 1'b0;
        regs_rd_valid = 1'b0;
        blit_rd_valid = 1'b0;
        if (!reset) begin
            case (rd_tag_q)
                VGEN:    vgen_rd_valid = 1'b1;
                REGS:    regs_rd_valid = 1'b1;
`ifdef VRAM_ARB_BLIT_EN
                BLIT:    blit_rd_valid = 1'b1;
`endif
                default: vgen_rd_valid = 1'b0;
            endcase
        end else begin
            vgen_rd_valid = 1'b0;
        end
    end

    assign rd_data = vram_data_out;

endmodule
